// File: rtl/regf_common_param_pkg.sv
// Shared regfile read-path parameters and types.
//   MASK_WORD_NB / BLWE_WORD_NB : regfile words per BLWE mask / whole BLWE
//   WORD_W                      : word index width inside one register
//   regf_rd_req_t               : PE read request {regid, start_word, word_nb_m1}
//   word_avail()                : per-coefficient valid mask of a BLWE word
package regf_common_param_pkg;
    localparam int REGF_COEF_NB  = 32;
    localparam int MOD_Q_W       = 64;
    localparam int BLWE_K        = 630;
    localparam int REGID_W       = 6;
    localparam int RAM_LATENCY   = 2;

    localparam int MASK_WORD_NB  = (BLWE_K + REGF_COEF_NB - 1) / REGF_COEF_NB;
    localparam int BLWE_WORD_NB  = MASK_WORD_NB + 1;
    localparam int WORD_W        = $clog2(BLWE_WORD_NB);
    localparam int REGF_RD_REQ_W = REGID_W + 2 * WORD_W;

    typedef struct packed {
        logic [REGID_W-1:0] regid;
        logic [WORD_W-1:0]  start_word;
        logic [WORD_W-1:0]  word_nb_m1;
    } regf_rd_req_t;

    typedef enum logic {
        ST_IDLE,
        ST_READ
    } rd_state_e;

    // Full mask words are dense; the last mask word is only filled up to
    // BLWE_K; the body word carries a single coefficient in lane 0.
    function automatic logic [REGF_COEF_NB-1:0] word_avail(input logic [WORD_W-1:0] w);
        logic [REGF_COEF_NB-1:0] a;
        a = '0;
        if (int'(w) < MASK_WORD_NB - 1) begin
            a = '1;
        end else if (int'(w) == MASK_WORD_NB - 1) begin
            for (int i = 0; i < REGF_COEF_NB; i++)
                a[i] = ((int'(w) * REGF_COEF_NB + i) < BLWE_K);
        end else if (int'(w) == MASK_WORD_NB) begin
            a[0] = 1'b1;
        end
        return a;
    endfunction
endpackage

// File: rtl/regf_pep_rd_server_if.sv
// PE <-> regfile read channel.
//   request : pep_regf_rd_req_vld / _rdy / pep_regf_rd_req (PE -> regfile)
//   data    : regf_pep_rd_data_avail, _data, _last_word, _is_body, _last_mask
//             (regfile -> PE, no backpressure)
// master = PE loader side, slave = regfile read server side.
interface regf_pep_rd_server_if;
    import regf_common_param_pkg::*;

    logic                              pep_regf_rd_req_vld;
    logic                              pep_regf_rd_req_rdy;
    regf_rd_req_t                      pep_regf_rd_req;
    logic [REGF_COEF_NB-1:0]           regf_pep_rd_data_avail;
    logic [REGF_COEF_NB*MOD_Q_W-1:0]   regf_pep_rd_data;
    logic                              regf_pep_rd_last_word;
    logic                              regf_pep_rd_is_body;
    logic                              regf_pep_rd_last_mask;

    modport master (
        output pep_regf_rd_req_vld, pep_regf_rd_req,
        input  pep_regf_rd_req_rdy,
        input  regf_pep_rd_data_avail, regf_pep_rd_data,
        input  regf_pep_rd_last_word, regf_pep_rd_is_body, regf_pep_rd_last_mask
    );

    modport slave (
        input  pep_regf_rd_req_vld, pep_regf_rd_req,
        output pep_regf_rd_req_rdy,
        output regf_pep_rd_data_avail, regf_pep_rd_data,
        output regf_pep_rd_last_word, regf_pep_rd_is_body, regf_pep_rd_last_mask
    );
endinterface

// File: rtl/regf_rd_sideband_pipe.sv
// Valid + payload delay line, DEPTH cycles, async active-high reset.
//   in_vld/in_data   : sampled every clk
//   out_vld/out_data : in_* delayed by DEPTH cycles (DEPTH >= 1)
module regf_rd_sideband_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         a_rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    output logic [W-1:0] out_data
);
    logic [DEPTH-1:0]        vld_pipe;
    logic [DEPTH-1:0][W-1:0] dat_pipe;

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            dat_pipe[0] <= in_data;
            for (int k = 1; k < DEPTH; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign out_vld  = vld_pipe[DEPTH-1];
    assign out_data = dat_pipe[DEPTH-1];
endmodule

// File: rtl/regf_pep_rd_server.sv
// Regfile read server for the PE BLWE loader.
//   clk, a_rst       : clock, async active-high reset
//   pep              : request handshake in, avail-qualified word stream out
//   ram_rd_en/_add   : regfile RAM read strobe and {regid, word} address
//   ram_rd_data      : RAM data, RAM_LATENCY cycles after ram_rd_en
//   rd_error         : one-cycle pulse when a request overruns the BLWE
// One request in flight; one RAM read per cycle while in READ; words come
// back RAM_LATENCY+1 cycles after their read, flagged and lane-masked.
module regf_pep_rd_server
    import regf_common_param_pkg::*;
(
    input  logic                            clk,
    input  logic                            a_rst,
    regf_pep_rd_server_if.slave             pep,
    output logic                            ram_rd_en,
    output logic [REGID_W+WORD_W-1:0]       ram_rd_add,
    input  logic [REGF_COEF_NB*MOD_Q_W-1:0] ram_rd_data,
    output logic                            rd_error
);
    localparam int SB_W = WORD_W + 1;

    rd_state_e          state, state_nxt;
    regf_rd_req_t       req;
    logic [REGID_W-1:0] regid_q;
    logic [WORD_W-1:0]  word_cnt, rem;
    logic               rdy_en, rdy, acc, bad;

    assign req = pep.pep_regf_rd_req;
    // rdy_en keeps rdy low through reset and rises on the first clock after.
    assign rdy = (state == ST_IDLE) & rdy_en;
    assign acc = pep.pep_regf_rd_req_vld & rdy;
    assign bad = ({1'b0, req.start_word} + {1'b0, req.word_nb_m1}) >= (WORD_W+1)'(BLWE_WORD_NB);
    assign pep.pep_regf_rd_req_rdy = rdy;

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state    <= ST_IDLE;
            rdy_en   <= 1'b0;
            rd_error <= 1'b0;
            regid_q  <= '0;
            word_cnt <= '0;
            rem      <= '0;
        end else begin
            state    <= state_nxt;
            rdy_en   <= 1'b1;
            rd_error <= acc & bad;
            if (acc) begin
                regid_q  <= req.regid;
                word_cnt <= req.start_word;
                rem      <= req.word_nb_m1;
            end else if (state == ST_READ) begin
                word_cnt <= word_cnt + 1'b1;
                rem      <= rem - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ram_rd_en = 1'b0;
        unique case (state)
            ST_IDLE: if (pep.pep_regf_rd_req_vld && rdy_en && !bad) state_nxt = ST_READ;
            ST_READ: begin
                ram_rd_en = 1'b1;
                if (rem == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign ram_rd_add = {regid_q, word_cnt};

    // {word, last} travels with each read so the output stage sees it
    // aligned with the RAM data.
    logic [SB_W-1:0]   sb_in, sb_out;
    logic              sb_vld;
    logic [WORD_W-1:0] tail_word;
    logic              tail_last;

    assign sb_in = {word_cnt, rem == '0};

    regf_rd_sideband_pipe #(.DEPTH(RAM_LATENCY), .W(SB_W)) u_sb_pipe (
        .clk      (clk),
        .a_rst    (a_rst),
        .in_vld   (ram_rd_en),
        .in_data  (sb_in),
        .out_vld  (sb_vld),
        .out_data (sb_out)
    );

    assign tail_word = sb_out[SB_W-1:1];
    assign tail_last = sb_out[0];

    logic [REGF_COEF_NB-1:0]              avail_nxt, avail_q;
    logic [REGF_COEF_NB-1:0][MOD_Q_W-1:0] rd_coef, data_nxt, data_q;
    logic                                 last_word_q, is_body_q, last_mask_q;

    assign rd_coef   = ram_rd_data;
    assign avail_nxt = sb_vld ? word_avail(tail_word) : '0;

    always_comb begin
        data_nxt = '0;
        for (int i = 0; i < REGF_COEF_NB; i++)
            if (avail_nxt[i]) data_nxt[i] = rd_coef[i];
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            avail_q     <= '0;
            data_q      <= '0;
            last_word_q <= 1'b0;
            is_body_q   <= 1'b0;
            last_mask_q <= 1'b0;
        end else begin
            avail_q     <= avail_nxt;
            data_q      <= data_nxt;
            last_word_q <= sb_vld & tail_last;
            is_body_q   <= sb_vld & (tail_word == WORD_W'(MASK_WORD_NB));
            last_mask_q <= sb_vld & (tail_word == WORD_W'(MASK_WORD_NB - 1));
        end
    end

    assign pep.regf_pep_rd_data_avail = avail_q;
    assign pep.regf_pep_rd_data       = data_q;
    assign pep.regf_pep_rd_last_word  = last_word_q;
    assign pep.regf_pep_rd_is_body    = is_body_q;
    assign pep.regf_pep_rd_last_mask  = last_mask_q;
endmodule

// File: tb/tb_regf_pep_rd_server.sv
// Bench for regf_pep_rd_server: directed scenarios followed by random
// requests, with a transaction-level model predicting every RAM read,
// output word and error pulse together with the cycle it must appear in.
module tb_regf_pep_rd_server;
    typedef logic [31:0][63:0] word_t;

    typedef struct {
        int cyc;
        int addr;
    } iss_t;

    typedef struct {
        int          cyc;
        logic [31:0] avail;
        word_t       data;
        logic        lw, body, lm;
    } out_t;

    logic        clk = 1'b0;
    logic        a_rst;
    logic        ram_rd_en;
    logic [10:0] ram_rd_add;
    logic [2047:0] ram_rd_data;
    logic        rd_error;

    regf_pep_rd_server_if pep ();

    regf_pep_rd_server dut (
        .clk         (clk),
        .a_rst       (a_rst),
        .pep         (pep.slave),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_add  (ram_rd_add),
        .ram_rd_data (ram_rd_data),
        .rd_error    (rd_error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int srv_free = 0;
    int acc_last = 0;
    logic [31:0] seed;

    iss_t iq[$];
    out_t oq[$];
    int   eq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // RAM content is a fixed function of the address (and a random seed).
    function automatic word_t ram_word(input int addr);
        word_t w;
        for (int i = 0; i < 32; i++)
            w[i] = {seed ^ 32'(addr * 32'h9E3779B1), 16'(addr), 16'(i)};
        return w;
    endfunction

    word_t rp1, rp2;
    always @(posedge clk) begin
        rp1 <= ram_word(int'(ram_rd_add));
        rp2 <= rp1;
    end
    assign ram_rd_data = rp2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_data(input string tag, input word_t obs, input word_t exp);
        int idx = 0;
        for (int i = 31; i >= 0; i--) if (obs[i] !== exp[i]) idx = i;
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: coef %0d observed %0h expected %0h", tag, idx, obs[idx], exp[idx]);
    endtask

    // Model: a word's lanes hold coefficients w*32+i; mask words carry
    // coefficients below 630, the body word (20) carries exactly one.
    task automatic model_req(input int acc, input int rid, input int st, input int nb);
        if (st + nb >= 21) begin
            eq.push_back(acc + 1);
            srv_free = acc + 1;
        end else begin
            for (int k = 0; k <= nb; k++) begin
                iss_t  e;
                out_t  o;
                word_t rw;
                int    w;
                w      = st + k;
                e.cyc  = acc + 1 + k;
                e.addr = rid * 32 + w;
                iq.push_back(e);
                rw = ram_word(e.addr);
                o.cyc = acc + 4 + k;
                o.avail = '0;
                o.data  = '0;
                for (int i = 0; i < 32; i++) begin
                    if (w < 20) o.avail[i] = (w * 32 + i < 630);
                    else        o.avail[i] = (i == 0);
                    if (o.avail[i]) o.data[i] = rw[i];
                end
                o.lw   = (k == nb);
                o.body = (w == 20);
                o.lm   = (w == 19);
                oq.push_back(o);
            end
            srv_free = acc + 2 + nb;
        end
    endtask

    // Output-side monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!a_rst) begin
            if (ram_rd_en) begin
                if (iq.size() == 0) chk("ram_stray", 1, 0);
                else begin
                    iss_t e;
                    e = iq.pop_front();
                    chk("ram_add", 64'(ram_rd_add), 64'(e.addr));
                    chk("ram_cyc", 64'(cyc), 64'(e.cyc));
                end
            end else if (iq.size() != 0 && iq[0].cyc <= cyc) begin
                chk("ram_missing", 0, 1);
                void'(iq.pop_front());
            end

            if (pep.regf_pep_rd_data_avail != '0) begin
                if (oq.size() == 0) chk("out_stray", 64'(pep.regf_pep_rd_data_avail), 0);
                else begin
                    out_t o;
                    o = oq.pop_front();
                    chk("out_cyc", 64'(cyc), 64'(o.cyc));
                    chk("avail", 64'(pep.regf_pep_rd_data_avail), 64'(o.avail));
                    chk("flags", {pep.regf_pep_rd_last_word, pep.regf_pep_rd_is_body,
                                  pep.regf_pep_rd_last_mask}, {o.lw, o.body, o.lm});
                    chk_data("data", pep.regf_pep_rd_data, o.data);
                end
            end else begin
                if (pep.regf_pep_rd_last_word || pep.regf_pep_rd_is_body ||
                    pep.regf_pep_rd_last_mask || (|pep.regf_pep_rd_data))
                    chk("idle_flags", 1, 0);
                if (oq.size() != 0 && oq[0].cyc <= cyc) begin
                    chk("out_missing", 0, 1);
                    void'(oq.pop_front());
                end
            end

            if (rd_error) begin
                if (eq.size() == 0) chk("err_stray", 1, 0);
                else chk("err_cyc", 64'(cyc), 64'(eq.pop_front()));
            end else if (eq.size() != 0 && eq[0] <= cyc) begin
                chk("err_missing", 0, 1);
                void'(eq.pop_front());
            end
        end
    end

    // Present a request from the falling edge, hold vld until rdy.
    // Returns just after the accepting edge with vld still high.
    task automatic send(input int rid, input int st, input int nb);
        int present, b, acc_m;
        @(negedge clk);
        pep.pep_regf_rd_req_vld = 1'b1;
        pep.pep_regf_rd_req     = {6'(rid), 5'(st), 5'(nb)};
        present = cyc;
        b = 0;
        while (!pep.pep_regf_rd_req_rdy && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (b == 100) begin
            chk("req_timeout", 0, 1);
            pep.pep_regf_rd_req_vld = 1'b0;
        end else begin
            acc_m = (present > srv_free) ? present : srv_free;
            chk("acc_cyc", 64'(cyc), 64'(acc_m));
            acc_last = acc_m;
            model_req(acc_m, rid, st, nb);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        pep.pep_regf_rd_req_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int b = 0;
        while ((iq.size() + oq.size() + eq.size()) != 0 && b < 400) begin
            @(posedge clk);
            #1;
            b++;
        end
        chk("drain", 64'(iq.size() + oq.size() + eq.size()), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},   64'(pep.pep_regf_rd_req_rdy), 0);
        chk({tag, "_ramen"}, 64'(ram_rd_en), 0);
        chk({tag, "_avail"}, 64'(pep.regf_pep_rd_data_avail), 0);
        chk({tag, "_err"},   64'(rd_error), 0);
        chk({tag, "_flags"}, {pep.regf_pep_rd_last_word, pep.regf_pep_rd_is_body,
                              pep.regf_pep_rd_last_mask, |pep.regf_pep_rd_data}, 0);
    endtask

    initial begin
        a_rst = 1'b1;
        seed  = $urandom;
        pep.pep_regf_rd_req_vld = 1'b0;
        pep.pep_regf_rd_req     = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        @(negedge clk);
        a_rst = 1'b0;
        srv_free = cyc + 1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 64'(pep.pep_regf_rd_req_rdy), 1);

        // Full BLWE read, then partial read.
        send(3, 0, 20);
        idle(1);
        drain();
        send(7, 5, 2);
        idle(1);
        drain();

        // Overrunning request: error pulse only, rdy stays up.
        send(9, 20, 1);
        chk("bad_rdy", 64'(pep.pep_regf_rd_req_rdy), 1);
        idle(1);
        chk("bad_rdy2", 64'(pep.pep_regf_rd_req_rdy), 1);
        drain();

        // Back-to-back with vld held high.
        send(1, 0, 3);
        send(2, 10, 4);
        idle(1);
        drain();

        // Async reset while word 10 is being read.
        send(3, 0, 20);
        idle(0);
        begin
            int b = 0;
            while (cyc != acc_last + 11 && b < 100) begin
                @(posedge clk);
                #1;
                b++;
            end
            if (b == 100) chk("rst_wait_timeout", 0, 1);
        end
        #1;
        a_rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        iq.delete();
        oq.delete();
        eq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_rst = 1'b0;
        srv_free = cyc + 1;
        @(posedge clk);
        #1;
        chk("rdy_after_midrst", 64'(pep.pep_regf_rd_req_rdy), 1);
        repeat (6) @(posedge clk);
        send(4, 2, 6);
        idle(1);
        drain();

        // Random requests, mixed gaps and back-to-back.
        for (int r = 0; r < 30; r++) begin
            int rid, st, nb;
            rid = $urandom_range(0, 63);
            st  = $urandom_range(0, 20);
            if ($urandom_range(0, 5) == 0) nb = $urandom_range(21 - st, 31);
            else                           nb = $urandom_range(0, 20 - st);
            send(rid, st, nb);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
        end
        idle(1);
        drain();
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
